ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, data width of each RAM word and each requester data port.
REQ-002 Address width SHALL be fixed at 10 bits (1K words): Addr[9:7] selects one of 8 banks, Addr[6:0] selects the row in that bank.
REQ-003 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-high.
REQ-005 ReqA / ReqB  input  1 each  access request from requester A / B.
REQ-006 WeA / WeB  input  1 each  1 = write, 0 = read.
REQ-007 AddrA / AddrB  input  10 each  word address.
REQ-008 DinA / DinB  input  DATA_W each  write data.
REQ-009 GntA / GntB  output  1 each  one-cycle pulse: request accepted and operands latched.
REQ-010 DoneA / DoneB  output  1 each  one-cycle pulse: access complete.
REQ-011 Dout  output  DATA_W  registered read data; valid when DoneA or DoneB is high.
REQ-012 Bank_En  output  8  one-hot RAM bank enable.
REQ-013 Row_Addr  output  7  RAM row address.
REQ-014 Ram_We  output  1  RAM write strobe.
REQ-015 Ram_Din  output  DATA_W  RAM write data.
REQ-016 Ram_Dout  input  DATA_W  RAM read data, valid in the cycle after the strobe.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS and DONE; the state SHALL be IDLE after reset.
REQ-018 IDLE: if neither ReqA nor ReqB is high, the FSM SHALL stay in IDLE.
REQ-019 IDLE: if exactly one request is high, that requester SHALL win.
REQ-020 IDLE: if both requests are high, the requester selected by the 1-bit priority register Pri (0 = A, 1 = B) SHALL win.
REQ-021 IDLE with a winner: the block SHALL latch the winner's We, Addr and Din plus a 1-bit owner flag, pulse the winner's Gnt for that cycle, and move to ACCESS.
REQ-022 ACCESS lasts one cycle: Bank_En SHALL equal the 3-to-8 one-hot decode of latched Addr[9:7], Row_Addr = Addr[6:0], Ram_Din = latched Din, Ram_We = latched We; the FSM then moves to DONE.
REQ-023 Outside ACCESS, Bank_En SHALL be 8'h00 and Ram_We SHALL be 0; Row_Addr and Ram_Din SHALL hold the latched values.
REQ-024 DONE: on a read, Dout SHALL capture Ram_Dout; on a write, Dout SHALL be unchanged.
REQ-025 DONE: the owner's Done SHALL pulse for one cycle, Pri SHALL be set to the non-owner, and the FSM SHALL return to IDLE.
REQ-026 Latency: Gnt to Done SHALL be exactly 2 cycles; back-to-back accesses SHALL occur at most once every 3 cycles.
REQ-027 Each requester SHALL hold Req until its Done; a Req deasserted after Gnt SHALL NOT abort the transaction.
REQ-028 Input changes after Gnt SHALL NOT affect the transaction in flight.
REQ-029 At most one Gnt and at most one Done SHALL be high in any cycle, and Gnt and Done SHALL never be high in the same cycle.
REQ-030 Under continuous requests from both sides, grants SHALL strictly alternate A, B, A, ...; no requester SHALL wait more than 6 cycles from IDLE.
REQ-031 Address 10'h3FF SHALL produce Bank_En = 8'h80 and Row_Addr = 7'h7F; address 10'h000 SHALL produce Bank_En = 8'h01 and Row_Addr = 7'h00.

Reset
REQ-032 RST high SHALL immediately force: state IDLE, Pri = 0, all Gnt/Done = 0, Bank_En = 0, Ram_We = 0, Dout = 0, latched Addr/Din/We = 0.
REQ-033 RST asserted mid-transaction SHALL abort it without a Done pulse, and the aborted transaction SHALL NOT be retried.
REQ-034 After RST deasserts, the first arbitration SHALL occur on the next rising edge.

Verification
REQ-035 Single write: ReqA, WeA=1, AddrA=10'h185, DinA=8'hA5 -> GntA at cycle t; at t+1 Bank_En=8'h08, Row_Addr=7'h05, Ram_We=1, Ram_Din=8'hA5; DoneA at t+2.
REQ-036 Single read: ReqB, WeB=0, AddrB=10'h3FF, model returns 8'h3C -> Bank_En=8'h80 at t+1, Ram_We=0; DoneB with Dout=8'h3C at t+2.
REQ-037 Contention: ReqA and ReqB both high from reset -> grant order A, B, A, B at cycles 0, 3, 6, 9; never two Gnt in one cycle.
REQ-038 Req dropped: ReqA deasserted the cycle after GntA -> access still strobes and DoneA pulses; no further GntA.
REQ-039 Reset mid-access: RST pulsed during ACCESS -> Bank_En=0 and Ram_We=0 at once; no Done pulse; Pri=0 afterwards, so A wins the next contention.
REQ-040 Idle: no requests for 20 cycles -> Bank_En=0, Ram_We=0, and no Gnt or Done throughout.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bus between two RAM requesters, the arbiter and the banked RAM.
// The arbiter takes the slave modport; the requester/RAM side takes the master modport.
interface ram_arbiter_if #(
  parameter int unsigned DATA_W = 8
);
  logic              req_a;
  logic              req_b;
  logic              we_a;
  logic              we_b;
  logic [9:0]        addr_a;
  logic [9:0]        addr_b;
  logic [DATA_W-1:0] din_a;
  logic [DATA_W-1:0] din_b;
  logic              gnt_a;
  logic              gnt_b;
  logic              done_a;
  logic              done_b;
  logic [DATA_W-1:0] dout;
  logic [7:0]        bank_en;
  logic [6:0]        row_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, din_a, din_b, ram_dout,
    output gnt_a, gnt_b, done_a, done_b, dout, bank_en, row_addr, ram_we, ram_din
  );

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, din_a, din_b, ram_dout,
    input  gnt_a, gnt_b, done_a, done_b, dout, bank_en, row_addr, ram_we, ram_din
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for an 8-bank RAM: grant, one-cycle strobe, then done.
// Round-robin between A and B when both request; every output is registered.
module ram_arbiter #(
  parameter int unsigned DATA_W = 8
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            state_q;
  logic              pri_q;
  logic              owner_q;
  logic              we_q;
  logic [9:0]        addr_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] dout_q;
  logic              gnt_a_q;
  logic              gnt_b_q;
  logic              done_a_q;
  logic              done_b_q;
  logic              ram_we_q;
  logic [7:0]        bank_en_q;
  logic              win_b;

  // B wins when it asks alone, or when both ask and B holds priority.
  assign win_b = bus.req_b & (~bus.req_a | pri_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pri_q     <= 1'b0;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      dout_q    <= '0;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      done_a_q  <= 1'b0;
      done_b_q  <= 1'b0;
      ram_we_q  <= 1'b0;
      bank_en_q <= '0;
    end else begin
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req_a || bus.req_b) begin
            owner_q <= win_b;
            we_q    <= win_b ? bus.we_b   : bus.we_a;
            addr_q  <= win_b ? bus.addr_b : bus.addr_a;
            din_q   <= win_b ? bus.din_b  : bus.din_a;
            gnt_a_q <= ~win_b;
            gnt_b_q <= win_b;
            state_q <= StAccess;
          end
        end
        StAccess: begin
          bank_en_q <= 8'h01 << addr_q[9:7];
          ram_we_q  <= we_q;
          state_q   <= StDone;
        end
        StDone: begin
          // Read data arrives while the strobe is presented and is captured here.
          if (!we_q) begin
            dout_q <= bus.ram_dout;
          end
          bank_en_q <= '0;
          ram_we_q  <= 1'b0;
          done_a_q  <= ~owner_q;
          done_b_q  <= owner_q;
          pri_q     <= ~owner_q;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.gnt_a    = gnt_a_q;
  assign bus.gnt_b    = gnt_b_q;
  assign bus.done_a   = done_a_q;
  assign bus.done_b   = done_b_q;
  assign bus.dout     = dout_q;
  assign bus.bank_en  = bank_en_q;
  assign bus.row_addr = addr_q[6:0];
  assign bus.ram_we   = ram_we_q;
  assign bus.ram_din  = din_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic, with a transaction-level
// model predicting grant/strobe/done events into a queue that a negedge monitor consumes.
module tb_ram_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  ram_arbiter_if #(.DATA_W(8)) bus ();

  ram_arbiter #(.DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_val(input logic [9:0] a);
    return a[7:0] ^ 8'hC3;
  endfunction

  function automatic logic [2:0] oh_idx(input logic [7:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (oh[i]) r = 3'(i);
    return r;
  endfunction

  // RAM device: asynchronous read of the strobed word, write on the strobe's closing edge.
  logic [7:0] ram_mem [1024];
  assign bus.ram_dout = ram_mem[{oh_idx(bus.bank_en), bus.row_addr}];

  initial begin
    for (int i = 0; i < 1024; i++) ram_mem[i] = init_val(10'(i));
    forever begin
      @(posedge clk);
      if (bus.bank_en != 8'h00 && bus.ram_we)
        ram_mem[{oh_idx(bus.bank_en), bus.row_addr}] = bus.ram_din;
    end
  end

  // Transaction-level reference model.
  typedef struct {
    int         win;
    int         kind;   // 0 grant, 1 strobe, 2 done
    bit         owner;  // 0 = A, 1 = B
    bit         we;
    logic [9:0] addr;
    logic [7:0] din;
    logic [7:0] rdata;
  } ev_t;

  ev_t             exp_q[$];
  logic [7:0]      mm[int];
  int              win = 0;
  int              free_at = 0;
  int              rst_cnt = 0;
  bit              m_pri;
  bit              m_who;
  ev_t             m_ev;
  logic [6:0]      m_row;
  logic [7:0]      m_din;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_pri   = 1'b0;
      free_at = 0;
      m_row   = '0;
      m_din   = '0;
      rst_cnt++;
    end else begin
      win++;
      if (win >= free_at && (bus.req_a || bus.req_b)) begin
        m_who      = (bus.req_a && bus.req_b) ? m_pri : bus.req_b;
        m_ev.owner = m_who;
        m_ev.we    = m_who ? bus.we_b   : bus.we_a;
        m_ev.addr  = m_who ? bus.addr_b : bus.addr_a;
        m_ev.din   = m_who ? bus.din_b  : bus.din_a;
        m_ev.rdata = mm.exists(int'(m_ev.addr)) ? mm[int'(m_ev.addr)] : init_val(m_ev.addr);
        if (m_ev.we) mm[int'(m_ev.addr)] = m_ev.din;
        for (int k = 0; k < 3; k++) begin
          m_ev.win  = win + k;
          m_ev.kind = k;
          exp_q.push_back(m_ev);
        end
        free_at = win + 3;
        m_pri   = ~m_who;
        m_row   = m_ev.addr[6:0];
        m_din   = m_ev.din;
      end
    end
  end

  // Monitor: every falling edge, compare all outputs against the next expected event.
  int         mon_rst = 0;
  logic [7:0] exp_dout = 8'h00;
  ev_t        mon_ev;
  bit         e_ga, e_gb, e_da, e_db, e_we;
  logic [7:0] e_bank;

  always @(negedge clk) begin
    if (mon_rst != rst_cnt) begin
      exp_dout = 8'h00;
      mon_rst  = rst_cnt;
    end
    {e_ga, e_gb, e_da, e_db, e_we} = '0;
    e_bank = 8'h00;
    if (!rst) begin
      while (exp_q.size() > 0 && exp_q[0].win < win) begin
        chk("missed_event_window", 32'(exp_q[0].win), 32'(win));
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].win == win) begin
        mon_ev = exp_q.pop_front();
        case (mon_ev.kind)
          0: begin e_ga = ~mon_ev.owner; e_gb = mon_ev.owner; end
          1: begin e_bank = 8'h01 << mon_ev.addr[9:7]; e_we = mon_ev.we; end
          default: begin
            e_da = ~mon_ev.owner;
            e_db = mon_ev.owner;
            if (!mon_ev.we) exp_dout = mon_ev.rdata;
          end
        endcase
      end
    end
    chk("gnt_a", 32'(bus.gnt_a), 32'(e_ga));
    chk("gnt_b", 32'(bus.gnt_b), 32'(e_gb));
    chk("done_a", 32'(bus.done_a), 32'(e_da));
    chk("done_b", 32'(bus.done_b), 32'(e_db));
    chk("bank_en", 32'(bus.bank_en), 32'(e_bank));
    chk("ram_we", 32'(bus.ram_we), 32'(e_we));
    chk("row_addr", 32'(bus.row_addr), 32'(m_row));
    chk("ram_din", 32'(bus.ram_din), 32'(m_din));
    chk("dout", 32'(bus.dout), 32'(exp_dout));
  end

  // Stimulus helpers.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] rnd_addr();
    case ($urandom_range(0, 5))
      0:       return 10'h000;
      1:       return 10'h3FF;
      2:       return 10'h185;
      3:       return 10'h07F;
      4:       return 10'h200;
      default: return 10'($urandom_range(0, 1023));
    endcase
  endfunction

  task automatic set_side(input bit s, input bit r, input bit w, input logic [9:0] a,
                          input logic [7:0] d);
    if (s) begin
      bus.req_b = r; bus.we_b = w; bus.addr_b = a; bus.din_b = d;
    end else begin
      bus.req_a = r; bus.we_a = w; bus.addr_a = a; bus.din_a = d;
    end
  endtask

  task automatic rnd_side(input bit s, input bit r);
    set_side(s, r, 1'($urandom_range(0, 1)), rnd_addr(), 8'($urandom_range(0, 255)));
  endtask

  task automatic do_single(input bit s, input bit w, input logic [9:0] a, input logic [7:0] d,
                           input bit drop, output longint tg, output longint td);
    bit g, dn;
    tg = -1;
    td = -1;
    set_side(s, 1'b1, w, a, d);
    for (int i = 0; i < 20 && td < 0; i++) begin
      tick();
      g  = s ? bus.gnt_b  : bus.gnt_a;
      dn = s ? bus.done_b : bus.done_a;
      if (g) begin
        tg = $time;
        // Inputs may change freely once granted.
        set_side(s, drop ? 1'b0 : 1'b1, ~w, ~a, ~d);
      end
      if (dn) begin
        td = $time;
        set_side(s, 1'b0, w, a, d);
      end
    end
    chk("single_completes", 32'(tg >= 0 && td >= 0), 32'd1);
  endtask

  task automatic rand_step(input bit s, inout bit busy);
    bit g, dn, r;
    g  = s ? bus.gnt_b  : bus.gnt_a;
    dn = s ? bus.done_b : bus.done_a;
    r  = s ? bus.req_b  : bus.req_a;
    if (dn) begin
      busy = 1'b0;
      r    = 1'b0;
      set_side(s, 1'b0, 1'b0, 10'h000, 8'h00);
    end else if (g) begin
      busy = 1'b1;
      r    = ($urandom_range(0, 2) != 0);
      rnd_side(s, r);
    end
    if (!r && !busy && $urandom_range(0, 2) == 0) rnd_side(s, 1'b1);
  endtask

  longint tg, td, rel;
  longint gt[8];
  bit     own[8];
  int     ng, n;
  bit     found, busy_a, busy_b;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    set_side(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
    set_side(1'b1, 1'b0, 1'b0, 10'h000, 8'h00);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    do_single(1'b0, 1'b1, 10'h185, 8'hA5, 1'b0, tg, td);
    chk("write_latency", 32'((td - tg) / 10), 32'd2);
    do_single(1'b1, 1'b0, 10'h3FF, 8'h00, 1'b0, tg, td);
    chk("read_latency", 32'((td - tg) / 10), 32'd2);
    chk("read_dout_3ff", 32'(bus.dout), 32'h3C);
    do_single(1'b0, 1'b0, 10'h000, 8'h11, 1'b1, tg, td);
    chk("dropped_req_latency", 32'((td - tg) / 10), 32'd2);
    n = 0;
    repeat (8) begin tick(); n += int'(bus.gnt_a); end
    chk("dropped_req_no_regrant", 32'(n), 32'd0);

    n = 0;
    repeat (20) begin
      tick();
      if (bus.gnt_a || bus.gnt_b || bus.done_a || bus.done_b || bus.ram_we || bus.bank_en != 0)
        n++;
    end
    chk("idle_quiet", 32'(n), 32'd0);

    // Contention straight out of reset.
    rst = 1'b1;
    rnd_side(1'b0, 1'b1);
    rnd_side(1'b1, 1'b1);
    tick();
    rel = $time;
    rst = 1'b0;
    ng  = 0;
    for (int i = 0; i < 30 && ng < 6; i++) begin
      tick();
      if (bus.gnt_a || bus.gnt_b) begin
        own[ng] = bus.gnt_b;
        gt[ng]  = $time;
        ng++;
      end
      if (bus.done_a) rnd_side(1'b0, 1'b1);
      if (bus.done_b) rnd_side(1'b1, 1'b1);
    end
    chk("contention_grant_count", 32'(ng), 32'd6);
    chk("first_grant_after_reset", 32'((gt[0] - rel) / 10), 32'd1);
    for (int i = 0; i < ng; i++) begin
      chk("grant_owner_alternates", 32'(own[i]), 32'(i % 2));
      chk("grant_spacing", 32'((gt[i] - gt[0]) / 10), 32'(3 * i));
    end

    // Reset while the RAM strobe is on the bus.
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      tick();
      if (bus.gnt_a || bus.gnt_b) found = 1'b1;
      if (bus.done_a) rnd_side(1'b0, 1'b1);
      if (bus.done_b) rnd_side(1'b1, 1'b1);
    end
    chk("reset_test_grant_seen", 32'(found), 32'd1);
    tick();
    #1 rst = 1'b1;
    #1;
    chk("reset_clears_bank_en", 32'(bus.bank_en), 32'd0);
    chk("reset_clears_ram_we", 32'(bus.ram_we), 32'd0);
    #1 rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      tick();
      if (bus.gnt_a || bus.gnt_b) begin
        found = 1'b1;
        chk("a_wins_after_reset", 32'(bus.gnt_a), 32'd1);
      end
    end
    chk("post_reset_grant_seen", 32'(found), 32'd1);

    // Random traffic; A currently owns the arbiter, B is still waiting.
    busy_a = 1'b1;
    busy_b = 1'b0;
    repeat (400) begin
      tick();
      rand_step(1'b0, busy_a);
      rand_step(1'b1, busy_b);
    end
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    repeat (10) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
